// File: rtl/bus_dma_initiator.sv
// Single-channel memory-to-memory copy engine acting as a femto bus initiator.
// Each read/write pair moves the widest chunk (4, 2 or 1 bytes) that alignment and remaining count allow.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_dma_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src,
  input  logic [ADDR_WIDTH-1:0]     dst,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_WIDTH-1:0]     err_addr,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic                      w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     wdata,
  input  logic [`BUS_WIDTH-1:0]     rdata,
  output logic                      req,
  input  logic                      resp,
  input  logic                      fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int BW = `BUS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_FIN, S_ERR
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   src_r, src_s, dst_r, dst_s, src_inc_s, dst_inc_s;
  logic [LEN_WIDTH-1:0]    rem_r, rem_s, rem_dec_s;
  logic [BW-1:0]           buf_r, buf_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic [2:0]              wid_r, wid_s, w_s;
  logic                    busy_s, done_s, err_s, w_rb_s, req_s;
  logic [ADDR_WIDTH-1:0]   err_addr_s, addr_s;
  logic [`BUS_ACC_WIDTH-1:0] acc_s;
  logic [BW-1:0]           wdata_s;

  // Widest chunk both addresses are aligned to that still fits in the remaining count
  function automatic logic [2:0] chunk_w(input logic [1:0] s, input logic [1:0] d,
                                         input logic [LEN_WIDTH-1:0] r);
    if ((s == 2'b00) && (d == 2'b00) && (r >= LEN_WIDTH'(4))) return 3'd4;
    else if ((s[0] == 1'b0) && (d[0] == 1'b0) && (r >= LEN_WIDTH'(2))) return 3'd2;
    else return 3'd1;
  endfunction

  function automatic logic [`BUS_ACC_WIDTH-1:0] acc_of(input logic [2:0] w);
    case (w)
      3'd4:    return `BUS_ACC_4B;
      3'd2:    return `BUS_ACC_2B;
      default: return `BUS_ACC_1B;
    endcase
  endfunction

  function automatic logic [BW-1:0] mask_w(input logic [BW-1:0] d, input logic [2:0] w);
    case (w)
      3'd4:    return d;
      3'd2:    return BW'(d[15:0]);
      default: return BW'(d[7:0]);
    endcase
  endfunction

  assign src_inc_s = src_r + ADDR_WIDTH'(wid_r);
  assign dst_inc_s = dst_r + ADDR_WIDTH'(wid_r);
  assign rem_dec_s = rem_r - LEN_WIDTH'(wid_r);

  // Next-state and next-output computation; every output is registered below
  always_comb begin
    state_s = state_r; src_s = src_r; dst_s = dst_r; rem_s = rem_r;
    buf_s = buf_r; cnt_s = cnt_r; wid_s = wid_r; w_s = 3'd1;
    busy_s = busy; done_s = 1'b0; err_s = err; err_addr_s = err_addr;
    addr_s = addr; w_rb_s = w_rb; acc_s = acc; wdata_s = wdata; req_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          err_s = 1'b0;
          err_addr_s = '0;
          if (len != LEN_WIDTH'(0)) begin
            w_s = chunk_w(src[1:0], dst[1:0], len);
            src_s = src; dst_s = dst; rem_s = len; wid_s = w_s; busy_s = 1'b1;
            req_s = 1'b1; w_rb_s = 1'b0; addr_s = src; acc_s = acc_of(w_s);
            state_s = S_RD_REQ;
          end else begin
            done_s = 1'b1;
            state_s = S_FIN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        if (fault) begin
          err_s = 1'b1; err_addr_s = addr; done_s = 1'b1; busy_s = 1'b0;
          state_s = S_ERR;
        end else begin
          cnt_s = '0;
          state_s = (state_r == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (resp && (state_r == S_RD_WAIT)) begin
          buf_s = mask_w(rdata, wid_r);
          req_s = 1'b1; w_rb_s = 1'b1; addr_s = dst_r; wdata_s = buf_s;
          state_s = S_WR_REQ;
        end else if (resp) begin
          src_s = src_inc_s; dst_s = dst_inc_s; rem_s = rem_dec_s;
          if (rem_dec_s == LEN_WIDTH'(0)) begin
            done_s = 1'b1; busy_s = 1'b0;
            state_s = S_FIN;
          end else begin
            // Width of the next pair follows the advanced pointers
            w_s = chunk_w(src_inc_s[1:0], dst_inc_s[1:0], rem_dec_s);
            wid_s = w_s;
            req_s = 1'b1; w_rb_s = 1'b0; addr_s = src_inc_s; acc_s = acc_of(w_s);
            state_s = S_RD_REQ;
          end
        end else if ((cnt_r + CW'(1)) == CW'(TIMEOUT)) begin
          err_s = 1'b1; err_addr_s = addr; done_s = 1'b1; busy_s = 1'b0;
          state_s = S_ERR;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_FIN, S_ERR: state_s = S_IDLE;
      default:      state_s = S_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE; src_r <= '0; dst_r <= '0; rem_r <= '0; buf_r <= '0;
      cnt_r <= '0; wid_r <= 3'd1;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; err_addr <= '0; addr <= '0;
      w_rb <= 1'b0; acc <= `BUS_ACC_1B; wdata <= '0; req <= 1'b0;
    end else begin
      state_r <= state_s; src_r <= src_s; dst_r <= dst_s; rem_r <= rem_s; buf_r <= buf_s;
      cnt_r <= cnt_s; wid_r <= wid_s;
      busy <= busy_s; done <= done_s; err <= err_s; err_addr <= err_addr_s; addr <= addr_s;
      w_rb <= w_rb_s; acc <= acc_s; wdata <= wdata_s; req <= req_s;
    end
  end

endmodule

// File: tb/tb_bus_dma_initiator.sv
// Directed self-checking bench for bus_dma_initiator with a 1-cycle byte-addressed responder.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_dma_initiator;
  logic clk, rst, start, busy, done, err, w_rb, req, resp, fault;
  logic [31:0] src, dst, err_addr, addr, wdata, rdata;
  logic [15:0] len;
  logic [`BUS_ACC_WIDTH-1:0] acc;

  logic [7:0]  mem [0:511];
  logic [31:0] log_addr [0:63];
  logic [31:0] log_wdata [0:63];
  logic        log_w [0:63];
  logic [1:0]  log_acc [0:63];
  int ntx = 0;
  int errors = 0;
  int checks = 0;
  logic silent, fault_en;
  logic [31:0] fault_addr;

  bus_dma_initiator #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .addr(addr),
    .w_rb(w_rb), .acc(acc), .wdata(wdata), .rdata(rdata), .req(req),
    .resp(resp), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] * 8'd37 + 8'd5;
  endfunction

  assign fault = req & fault_en & w_rb & (addr == fault_addr);

  // Responder: answers one cycle after req, reads come from the address pattern
  always @(posedge clk) begin
    resp <= 1'b0;
    if (req) begin
      if (ntx < 64) begin
        log_addr[ntx] <= addr; log_w[ntx] <= w_rb; log_acc[ntx] <= acc; log_wdata[ntx] <= wdata;
      end
      ntx <= ntx + 1;
      if (!fault && !silent) begin
        resp <= 1'b1;
        if (w_rb) begin
          mem[addr[8:0]] <= wdata[7:0];
          if (acc != `BUS_ACC_1B) mem[addr[8:0] + 9'd1] <= wdata[15:8];
          if (acc == `BUS_ACC_4B) begin
            mem[addr[8:0] + 9'd2] <= wdata[23:16];
            mem[addr[8:0] + 9'd3] <= wdata[31:24];
          end
        end else begin
          rdata <= {pat(addr + 32'd3), pat(addr + 32'd2), pat(addr + 32'd1), pat(addr)};
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle in which done is seen, counting from the current cycle c0; -1 on overrun
  task automatic wait_done(input int c0, output int dc);
    dc = c0;
    while (!done && dc < 200) begin
      @(negedge clk);
      dc++;
    end
    if (!done) dc = -1;
  endtask

  task automatic check_txn(input string tag, input int idx, input logic [31:0] a,
                           input logic w, input logic [1:0] ac);
    check({tag, "_addr"}, log_addr[idx], a);
    check({tag, "_wrb"}, 32'(log_w[idx]), 32'(w));
    check({tag, "_acc"}, 32'(log_acc[idx]), 32'(ac));
  endtask

  int dc, base;

  initial begin
    rst = 1'b1; start = 1'b0; src = 32'h0; dst = 32'h0; len = 16'h0;
    silent = 1'b0; fault_en = 1'b0; fault_addr = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_req", 32'(req), 32'h0);
    check("rst_acc", 32'(acc), 32'(`BUS_ACC_1B));
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    rst = 1'b0;

    // Aligned copy of 8 bytes
    base = ntx;
    start_copy(32'h0, 32'h100, 16'd8);
    check("al_busy1", 32'(busy), 32'h1);
    wait_done(1, dc);
    check("al_done_cyc", 32'(dc), 32'd9);
    check("al_busy_at_done", 32'(busy), 32'h0);
    check("al_err", 32'(err), 32'h0);
    check("al_ntx", 32'(ntx - base), 32'd4);
    check_txn("al_t0", base + 0, 32'h0,   1'b0, `BUS_ACC_4B);
    check_txn("al_t1", base + 1, 32'h100, 1'b1, `BUS_ACC_4B);
    check_txn("al_t2", base + 2, 32'h4,   1'b0, `BUS_ACC_4B);
    check_txn("al_t3", base + 3, 32'h104, 1'b1, `BUS_ACC_4B);
    for (int i = 0; i < 8; i++) check("al_mem", 32'(mem[9'h100 + 9'(i)]), 32'(pat(32'(i))));

    // Mixed alignment: 2B, 4B, 1B
    base = ntx;
    start_copy(32'h2, 32'h6, 16'd7);
    wait_done(1, dc);
    check("mx_done_cyc", 32'(dc), 32'd13);
    check("mx_ntx", 32'(ntx - base), 32'd6);
    check_txn("mx_t0", base + 0, 32'h2, 1'b0, `BUS_ACC_2B);
    check_txn("mx_t1", base + 1, 32'h6, 1'b1, `BUS_ACC_2B);
    check_txn("mx_t2", base + 2, 32'h4, 1'b0, `BUS_ACC_4B);
    check_txn("mx_t3", base + 3, 32'h8, 1'b1, `BUS_ACC_4B);
    check_txn("mx_t4", base + 4, 32'h8, 1'b0, `BUS_ACC_1B);
    check_txn("mx_t5", base + 5, 32'hC, 1'b1, `BUS_ACC_1B);
    check("mx_wd1", log_wdata[base + 1], {16'h0, pat(32'h3), pat(32'h2)});
    for (int i = 0; i < 7; i++) check("mx_mem", 32'(mem[9'h6 + 9'(i)]), 32'(pat(32'h2 + 32'(i))));

    // Mismatched alignment: three 1B pairs, upper wdata bytes zero
    base = ntx;
    start_copy(32'h1, 32'h4, 16'd3);
    wait_done(1, dc);
    check("mm_done_cyc", 32'(dc), 32'd13);
    for (int i = 0; i < 3; i++) begin
      check_txn("mm_rd", base + 2 * i, 32'h1 + 32'(i), 1'b0, `BUS_ACC_1B);
      check_txn("mm_wr", base + 2 * i + 1, 32'h4 + 32'(i), 1'b1, `BUS_ACC_1B);
      check("mm_wdata", log_wdata[base + 2 * i + 1], {24'h0, pat(32'h1 + 32'(i))});
    end

    // Fault on the second write
    base = ntx;
    fault_en = 1'b1; fault_addr = 32'h104;
    start_copy(32'h0, 32'h100, 16'd8);
    wait_done(1, dc);
    check("ft_done_cyc", 32'(dc), 32'd8);
    check("ft_err", 32'(err), 32'h1);
    check("ft_err_addr", err_addr, 32'h104);
    check("ft_busy", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);
    check("ft_no_more_req", 32'(ntx - base), 32'd4);
    check("ft_err_held", 32'(err), 32'h1);
    fault_en = 1'b0;

    // len=0 clears err, pulses done, no bus traffic
    base = ntx;
    start_copy(32'h0, 32'h100, 16'd0);
    wait_done(1, dc);
    check("z_done_cyc", 32'(dc), 32'd1);
    check("z_err_clr", 32'(err), 32'h0);
    repeat (2) @(negedge clk);
    check("z_ntx", 32'(ntx - base), 32'd0);

    // Timeout on the first read
    silent = 1'b1;
    start_copy(32'h0, 32'h100, 16'd4);
    wait_done(1, dc);
    check("to_done_cyc", 32'(dc), 32'd6);
    check("to_err", 32'(err), 32'h1);
    check("to_err_addr", err_addr, 32'h0);
    silent = 1'b0;

    // start while busy is ignored
    base = ntx;
    start_copy(32'h0, 32'h180, 16'd4);
    @(negedge clk);
    src = 32'h40; dst = 32'h1A0; len = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, dc);
    check("sb_done_cyc", 32'(dc), 32'd5);
    check("sb_err", 32'(err), 32'h0);
    repeat (3) @(negedge clk);
    check("sb_ntx", 32'(ntx - base), 32'd2);
    check("sb_t1_addr", log_addr[base + 1], 32'h180);

    // Reset during RD_WAIT, then a normal copy
    silent = 1'b1;
    start_copy(32'h0, 32'h100, 16'd4);
    @(negedge clk);
    check("rw_busy_pre", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rw_busy", 32'(busy), 32'h0);
    check("rw_req", 32'(req), 32'h0);
    check("rw_addr", addr, 32'h0);
    check("rw_wrb", 32'(w_rb), 32'h0);
    @(negedge clk);
    rst = 1'b0; silent = 1'b0;
    start_copy(32'h0, 32'h1C0, 16'd4);
    wait_done(1, dc);
    check("rw_done_cyc", 32'(dc), 32'd5);
    check("rw_err", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) check("rw_mem", 32'(mem[9'h1C0 + 9'(i)]), 32'(pat(32'(i))));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_dma_initiator.md
# bus_dma_initiator

Single-channel memory-to-memory copy engine that drives the femto system bus as an initiator. It copies a byte range from a source address to a destination address by issuing alternating read and write transactions. Each transaction uses the widest access the current alignment allows. It sits beside the CPU as a second bus initiator and targets responders such as the TCM and peripheral controllers.

## Interface
- ADDR_WIDTH, 32: bus virtual address width.
- LEN_WIDTH, 16: width of the byte-count operand.
- TIMEOUT, 255: maximum cycles to wait for `resp` after a `req` before declaring an error; must be ≥1.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous assert, active-high.
- start  in  1  one-cycle pulse that launches a copy; ignored while `busy`=1.
- src  in  ADDR_WIDTH  source byte address, sampled on `start`.
- dst  in  ADDR_WIDTH  destination byte address, sampled on `start`.
- len  in  LEN_WIDTH  byte count, sampled on `start`.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse when the copy ends, whether it ends normally or with an error.
- err  out  1  copy ended on bus fault or timeout; held until the next accepted `start`.
- err_addr  out  ADDR_WIDTH  bus address of the failing transaction; held with `err`.
- addr  out  ADDR_WIDTH  bus address.
- w_rb  out  1  1 = write, 0 = read.
- acc  out  `BUS_ACC_WIDTH`  access size: `BUS_ACC_1B`, `BUS_ACC_2B` or `BUS_ACC_4B`.
- wdata  out  `BUS_WIDTH`  write data, right-aligned.
- rdata  in  `BUS_WIDTH`  read data, right-aligned; valid in the `resp` cycle.
- req  out  1  one-cycle transaction strobe.
- resp  in  1  transaction complete; arrives one or more cycles after `req`.
- fault  in  1  combinational reject, valid only in the `req` cycle.

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, err=0, err_addr=0, addr=0, w_rb=0, acc=`BUS_ACC_1B`, wdata=0, req=0.
- Internal registers: src pointer, dst pointer, remaining count, data buffer, and a timeout counter of width clog2(TIMEOUT+1).

**Bus protocol (initiator side)**
- addr, w_rb, acc and wdata are valid only in the cycle `req`=1.
- `fault`=1 in the `req` cycle aborts the transaction; no `resp` follows.
- Otherwise the initiator waits for `resp`.
- A new `req` is never issued before the previous `resp` or `fault`.

**Chunk width per transaction pair**
- The width w is chosen from 4, 2, 1, in that order.
- w is the first value for which both `src[1:0]` and `dst[1:0]` are multiples of w and remaining ≥ w.
- The read and the following write of a pair use the same acc.

**States**
- IDLE: on `start` with `len`≠0, latch src/dst/len, clear err, set busy, go to RD_REQ. With `len`=0, pulse `done` next cycle, no bus traffic, err cleared.
- RD_REQ: drive req=1, w_rb=0, addr=src pointer, acc for w. If `fault`, go to ERR. Otherwise go to RD_WAIT with the timeout counter at 0.
- RD_WAIT: on `resp`, capture rdata masked to w bytes and go to WR_REQ. Otherwise increment the counter; when it reaches TIMEOUT, go to ERR.
- WR_REQ: drive req=1, w_rb=1, addr=dst pointer, wdata=buffer. If `fault`, go to ERR. Otherwise go to WR_WAIT.
- WR_WAIT: on `resp`, add w to both pointers (modulo 2^ADDR_WIDTH, wrap silently) and subtract w from remaining. If remaining becomes 0, go to FIN; otherwise go to RD_REQ. Timeout is handled as in RD_WAIT.
- FIN: pulse done, busy=0, go to IDLE.
- ERR: err=1, err_addr=address of the failing transaction, pulse done, busy=0, go to IDLE. No further bus traffic.

**Boundary behaviour**
- `start` while busy: ignored, no effect.
- `resp` in IDLE or any REQ state: ignored.
- `rst` mid-copy: all state returns to reset values asynchronously. req drops immediately and the copy is abandoned.

## Timing
- `start` is sampled in cycle 0; the first read `req` is in cycle 1.
- Read `resp` in cycle k → write `req` in cycle k+1.
- Write `resp` in cycle m → next read `req` (or `done`) in cycle m+1.
- With a 1-cycle responder, each chunk costs 4 cycles, and `done` arrives in cycle 4·chunks+1.
- Fault abort: the fault is sampled in `req` cycle r; done=1, err=1 and err_addr valid in cycle r+1.
- Timeout: `req` in cycle r with no `resp` → done/err in cycle r+TIMEOUT+1.
- `busy` falls in the same cycle `done` pulses.

## Test plan
- **Aligned copy:** src=0x0, dst=0x100, len=8, 1-cycle responder → reads 0x0 and 0x4, writes 0x100 and 0x104, all `BUS_ACC_4B`; done in cycle 9; err=0; destination matches source.
- **Mixed alignment:** src=0x2, dst=0x6, len=7 → pairs of 2B@0x2→0x6, 4B@0x4→0x8, 1B@0x8→0xC; done in cycle 13.
- **Mismatched alignment:** src=0x1, dst=0x4, len=3 → three 1B pairs; wdata upper bytes are 0.
- **Fault:** responder asserts `fault` on the write to dst=0x104 → no further `req`; done=1, err=1, err_addr=0x104 in the next cycle; err clears on the next start.
- **Timeout:** TIMEOUT=4 and the responder never answers the read at 0x0 → done/err in cycle 6, err_addr=0x0.
- **Control corners:**
  - len=0 → done in cycle 1, no `req`.
  - `start` while busy → no effect.
  - `rst` asserted during RD_WAIT → all outputs return to reset values immediately; a later start works normally.
